// File: rtl/fill_r_collector_pkg.sv
// Shared constants and types for the fill R-channel collector.
package fill_r_collector_pkg;

    localparam int unsigned AXI_ID_WIDTH    = 4;
    localparam int unsigned AXI_ID          = 0;
    localparam int unsigned TID_WIDTH       = 4;
    localparam int unsigned AXI_DATA_WIDTH  = 256;
    localparam int unsigned LINE_WIDTH      = 512;
    localparam int unsigned FILL_TIDQ_DEPTH = 8;

    typedef enum logic [1:0] {
        RRESP_OKAY   = 2'b00,
        RRESP_EXOKAY = 2'b01,
        RRESP_SLVERR = 2'b10,
        RRESP_DECERR = 2'b11
    } rresp_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_OUT
    } state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RRESP_SLVERR) || (resp == RRESP_DECERR);
    endfunction

endpackage

// File: rtl/fill_tid_queue.sv
// In-order TID FIFO for outstanding fill reads; a push while full is dropped and
// flagged sticky, but a push coinciding with a pop at full is accepted.
module fill_tid_queue
    import fill_r_collector_pkg::*;
#(
    parameter int unsigned WIDTH = TID_WIDTH,
    parameter int unsigned DEPTH = FILL_TIDQ_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             empty_next_o,
    output logic             ovf_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q, ovf_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && !empty_q;
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_i && !do_push) begin
                ovf_q <= 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
        end
    end

    assign data_o       = mem_q[rd_ptr_q];
    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign empty_next_o = (count_d == '0);
    assign ovf_o        = ovf_q;

endmodule

// File: rtl/fill_r_collector.sv
// Assembles AXI R beats of fill reads into cache lines tagged with the in-order TID
// captured at AR issue, and presents them on a valid/ready fill-write interface.
module fill_r_collector
    import fill_r_collector_pkg::*;
#(
    parameter int unsigned          ID_WIDTH       = AXI_ID_WIDTH,
    parameter logic [ID_WIDTH-1:0]  ID             = ID_WIDTH'(AXI_ID),
    parameter int unsigned          TID_WIDTH      = fill_r_collector_pkg::TID_WIDTH,
    parameter int unsigned          AXI_DATA_WIDTH = fill_r_collector_pkg::AXI_DATA_WIDTH,
    parameter int unsigned          LINE_WIDTH     = fill_r_collector_pkg::LINE_WIDTH,
    parameter int unsigned          TIDQ_DEPTH     = FILL_TIDQ_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ar_fire_i,
    input  logic [TID_WIDTH-1:0]      ar_tid_i,
    output logic                      tidq_full_o,
    input  logic [ID_WIDTH-1:0]       rid_i,
    input  logic [AXI_DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]                rresp_i,
    input  logic                      rlast_i,
    input  logic                      rvalid_i,
    output logic                      rready_o,
    output logic                      fill_valid_o,
    input  logic                      fill_ready_i,
    output logic [LINE_WIDTH-1:0]     fill_data_o,
    output logic [TID_WIDTH-1:0]      fill_tid_o,
    output logic                      fill_err_o,
    output logic                      tidq_ovf_o
);

    localparam int unsigned BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
    // beat_cnt counts stored beats and saturates at BEATS once the line is full.
    localparam int unsigned CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] BEATS_C    = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] LAST_IDX_C = CNT_W'(BEATS - 1);

    state_e                  state_q;
    logic [CNT_W-1:0]        beat_cnt_q;
    logic [LINE_WIDTH-1:0]   line_q;
    logic [TID_WIDTH-1:0]    tid_q;
    logic                    err_q;
    logic                    fill_valid_q;
    logic                    rready_q;

    logic                    beat_acc, last_acc;
    logic [TID_WIDTH-1:0]    tidq_head;
    logic                    tidq_empty, tidq_empty_next;

    assign beat_acc = rvalid_i && rready_q;
    assign last_acc = beat_acc && rlast_i;

    fill_tid_queue #(
        .WIDTH (TID_WIDTH),
        .DEPTH (TIDQ_DEPTH)
    ) u_tid_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (ar_fire_i),
        .data_i       (ar_tid_i),
        .pop_i        (last_acc),
        .data_o       (tidq_head),
        .full_o       (tidq_full_o),
        .empty_o      (tidq_empty),
        .empty_next_o (tidq_empty_next),
        .ovf_o        (tidq_ovf_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            line_q       <= '0;
            tid_q        <= '0;
            err_q        <= 1'b0;
            fill_valid_q <= 1'b0;
            rready_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_COLLECT: begin
                    rready_q <= !tidq_empty_next;
                    if (beat_acc) begin
                        if (beat_cnt_q < BEATS_C) begin
                            for (int unsigned k = 0; k < BEATS; k++) begin
                                if (beat_cnt_q == CNT_W'(k)) begin
                                    line_q[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= rdata_i;
                                end
                            end
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        end
                        err_q <= err_q | resp_is_err(rresp_i) | (rid_i != ID)
                               | (beat_cnt_q >= BEATS_C)
                               | (rlast_i && (beat_cnt_q != LAST_IDX_C));
                        if (rlast_i) begin
                            tid_q        <= tidq_head;
                            fill_valid_q <= 1'b1;
                            rready_q     <= 1'b0;
                            state_q      <= S_OUT;
                        end else begin
                            state_q <= S_COLLECT;
                        end
                    end
                end
                S_OUT: begin
                    if (fill_ready_i) begin
                        fill_valid_q <= 1'b0;
                        beat_cnt_q   <= '0;
                        line_q       <= '0;
                        err_q        <= 1'b0;
                        rready_q     <= !tidq_empty_next;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rready_o     = rready_q;
    assign fill_valid_o = fill_valid_q;
    assign fill_data_o  = line_q;
    assign fill_tid_o   = tid_q;
    assign fill_err_o   = err_q;

    // Head is only read on a pop, which rready guarantees is non-empty.
    logic unused_empty;
    assign unused_empty = tidq_empty;

endmodule

// File: tb/tb_fill_r_collector.sv
// Randomised scoreboard bench for fill_r_collector against a line-level reference model.
module tb_fill_r_collector;
    import fill_r_collector_pkg::*;

    localparam int unsigned IDW   = AXI_ID_WIDTH;
    localparam int unsigned TW    = TID_WIDTH;
    localparam int unsigned DW    = AXI_DATA_WIDTH;
    localparam int unsigned LW    = LINE_WIDTH;
    localparam int unsigned BEATS = LW / DW;
    localparam int unsigned DEPTH = FILL_TIDQ_DEPTH;
    localparam logic [IDW-1:0] RID = IDW'(AXI_ID);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ar_fire = 1'b0;
    logic [TW-1:0]   ar_tid = '0;
    logic            tidq_full_o;
    logic [IDW-1:0]  rid = '0;
    logic [DW-1:0]   rdata = '0;
    logic [1:0]      rresp = '0;
    logic            rlast = 1'b0;
    logic            rvalid = 1'b0;
    logic            rready_o;
    logic            fill_valid_o;
    logic            fill_ready = 1'b1;
    logic [LW-1:0]   fill_data_o;
    logic [TW-1:0]   fill_tid_o;
    logic            fill_err_o;
    logic            tidq_ovf_o;

    fill_r_collector #(
        .ID_WIDTH       (IDW),
        .ID             (RID),
        .TID_WIDTH      (TW),
        .AXI_DATA_WIDTH (DW),
        .LINE_WIDTH     (LW),
        .TIDQ_DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ar_fire_i    (ar_fire),
        .ar_tid_i     (ar_tid),
        .tidq_full_o  (tidq_full_o),
        .rid_i        (rid),
        .rdata_i      (rdata),
        .rresp_i      (rresp),
        .rlast_i      (rlast),
        .rvalid_i     (rvalid),
        .rready_o     (rready_o),
        .fill_valid_o (fill_valid_o),
        .fill_ready_i (fill_ready),
        .fill_data_o  (fill_data_o),
        .fill_tid_o   (fill_tid_o),
        .fill_err_o   (fill_err_o),
        .tidq_ovf_o   (tidq_ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] data;
        logic [TW-1:0] tid;
        logic          err;
    } line_t;

    line_t         exp_q[$];
    logic [TW-1:0] tidm_q[$];
    int            n_chk = 0;
    int            n_pass = 0;

    logic [DW-1:0]  bd[8];
    logic [1:0]     br[8];
    logic [IDW-1:0] bi[8];

    int stall_left = 0;
    bit rand_ready = 1'b0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    function automatic logic [DW-1:0] rnd_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_beats_ok(input int nb);
        for (int i = 0; i < nb; i++) begin
            bd[i] = rnd_beat();
            br[i] = RRESP_OKAY;
            bi[i] = RID;
        end
    endtask

    task automatic push_tid(input logic [TW-1:0] t);
        ar_fire = 1'b1;
        ar_tid  = t;
        @(posedge clk);
        #1;
        ar_fire = 1'b0;
        if (tidm_q.size() < int'(DEPTH)) tidm_q.push_back(t);
    endtask

    // Expected line: beats beyond the line width are dropped; any length other than
    // BEATS, any error response or any foreign RID flags the line.
    task automatic send_line(input int nb, input int gap_max, input bit push_last,
                             input logic [TW-1:0] ptid);
        line_t e;
        int    w;
        e.data = '0;
        e.err  = (nb != int'(BEATS));
        e.tid  = tidm_q.pop_front();
        for (int i = 0; i < nb; i++) begin
            if (i < int'(BEATS)) e.data[i*DW +: DW] = bd[i];
            if (br[i][1] || bi[i] != RID) e.err = 1'b1;
        end
        exp_q.push_back(e);
        if (push_last) tidm_q.push_back(ptid);
        for (int i = 0; i < nb; i++) begin
            rvalid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            rvalid = 1'b1;
            rdata  = bd[i];
            rresp  = br[i];
            rid    = bi[i];
            rlast  = (i == nb - 1);
            w = 0;
            forever begin
                @(negedge clk);
                if (rready_o) break;
                w++;
                if (w > 200) break;
            end
            if (w > 200) begin
                chk("r_accept_timeout", 0, 1);
                rvalid = 1'b0;
                return;
            end
            if (push_last && i == nb - 1) begin
                ar_fire = 1'b1;
                ar_tid  = ptid;
            end
            @(posedge clk);
            #1;
            ar_fire = 1'b0;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Fill-write side ready generator with optional forced stall.
    always @(posedge clk) begin
        #1;
        if (stall_left > 0 && fill_valid_o) begin
            fill_ready = 1'b0;
            stall_left--;
        end else begin
            fill_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: checks hold-while-stalled and pops the scoreboard on each handshake.
    logic [LW-1:0] prev_data;
    logic [TW-1:0] prev_tid;
    logic          prev_err;
    bit            prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else if (fill_valid_o) begin
            chk("rready_low_while_valid", rready_o, 0);
            if (prev_stall) begin
                chk("hold_data", fill_data_o, prev_data);
                chk("hold_tid", fill_tid_o, prev_tid);
                chk("hold_err", fill_err_o, prev_err);
            end
            if (fill_ready) begin
                prev_stall = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_line", 1, 0);
                end else begin
                    line_t e;
                    e = exp_q.pop_front();
                    chk("line_data", fill_data_o, e.data);
                    chk("line_tid", fill_tid_o, e.tid);
                    chk("line_err", fill_err_o, e.err);
                end
            end else begin
                prev_stall = 1'b1;
                prev_data  = fill_data_o;
                prev_tid   = fill_tid_o;
                prev_err   = fill_err_o;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] pat_a, pat_b;
        pat_a = {(DW / 4){4'hA}};
        pat_b = {(DW / 4){4'hB}};

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rready", rready_o, 0);
        chk("rst_fill_valid", fill_valid_o, 0);
        chk("rst_fill_data", fill_data_o, 0);
        chk("rst_fill_tid", fill_tid_o, 0);
        chk("rst_fill_err", fill_err_o, 0);
        chk("rst_full", tidq_full_o, 0);
        chk("rst_ovf", tidq_ovf_o, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic line, rready and fill_valid latency.
        chk("rready_before_push", rready_o, 0);
        push_tid(4'h3);
        chk("rready_after_push", rready_o, 1);
        bd[0] = pat_a; br[0] = RRESP_OKAY; bi[0] = RID;
        bd[1] = pat_b; br[1] = RRESP_OKAY; bi[1] = RID;
        send_line(2, 0, 1'b0, '0);
        chk("fill_valid_latency", fill_valid_o, 1);
        wait_drain();

        // Three lines in order, line 2 stalled 4 cycles.
        push_tid(4'h1);
        push_tid(4'h2);
        push_tid(4'h3);
        set_beats_ok(2);
        send_line(2, 1, 1'b0, '0);
        wait_drain();
        @(negedge clk);
        stall_left = 4;
        @(posedge clk);
        #1;
        set_beats_ok(2);
        send_line(2, 1, 1'b0, '0);
        set_beats_ok(2);
        send_line(2, 1, 1'b0, '0);
        wait_drain();

        // Error response, then RID mismatch.
        push_tid(4'h7);
        push_tid(4'h8);
        set_beats_ok(2);
        br[0] = RRESP_SLVERR;
        send_line(2, 0, 1'b0, '0);
        set_beats_ok(2);
        bi[1] = RID ^ IDW'(1);
        send_line(2, 0, 1'b0, '0);
        wait_drain();

        // Short burst, then a clean line; extra-beat burst.
        push_tid(4'h9);
        push_tid(4'hA);
        push_tid(4'hB);
        set_beats_ok(1);
        send_line(1, 0, 1'b0, '0);
        set_beats_ok(2);
        send_line(2, 0, 1'b0, '0);
        set_beats_ok(3);
        send_line(3, 0, 1'b0, '0);
        wait_drain();

        // Queue full, push+pop at full, then overflow.
        for (int i = 0; i < int'(DEPTH); i++) push_tid(TW'(i + 2));
        chk("full_at_depth", tidq_full_o, 1);
        chk("no_ovf_at_depth", tidq_ovf_o, 0);
        set_beats_ok(2);
        send_line(2, 0, 1'b1, 4'hE);
        chk("full_after_push_pop", tidq_full_o, 1);
        chk("no_ovf_after_push_pop", tidq_ovf_o, 0);
        wait_drain();
        push_tid(4'hF);
        chk("ovf_after_extra_push", tidq_ovf_o, 1);
        chk("full_after_extra_push", tidq_full_o, 1);
        for (int i = 0; i < int'(DEPTH); i++) begin
            set_beats_ok(2);
            send_line(2, 1, 1'b0, '0);
        end
        wait_drain();
        chk("not_full_after_drain", tidq_full_o, 0);
        chk("ovf_sticky", tidq_ovf_o, 1);

        // Reset mid-burst discards the partial line and queued TIDs.
        push_tid(4'h5);
        push_tid(4'h6);
        rvalid = 1'b1; rdata = pat_a; rresp = RRESP_OKAY; rid = RID; rlast = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_rready", rready_o, 0);
        chk("mid_rst_valid", fill_valid_o, 0);
        chk("mid_rst_data", fill_data_o, 0);
        chk("mid_rst_ovf", tidq_ovf_o, 0);
        tidm_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rready_after_rst", rready_o, 0);
        end
        push_tid(4'h4);
        set_beats_ok(2);
        send_line(2, 0, 1'b0, '0);
        wait_drain();

        // Randomised traffic with random backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int r, nb, np;
            np = $urandom_range(0, 3);
            if (tidm_q.size() == 0) np = (np == 0) ? 1 : np;
            for (int p = 0; p < np; p++) begin
                if (tidm_q.size() < int'(DEPTH)) push_tid(TW'($urandom));
            end
            r  = $urandom_range(0, 9);
            nb = (r == 0) ? 1 : (r == 1) ? int'(BEATS) + 1 : int'(BEATS);
            set_beats_ok(nb);
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 9) == 0) br[i] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 19) == 0) bi[i] = IDW'($urandom);
            end
            send_line(nb, 2, 1'b0, '0);
        end
        rand_ready = 1'b0;
        wait_drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fill_r_collector.md
Name: fill_r_collector

Overview:
- Downstream neighbour of the fill AR FIFO.
- Consumes the AXI R channel returned by the CXL controller for fill reads and assembles BEATS beats into one cache line.
- Tags each line with the transaction ID (TID) captured when its AR was issued, then hands the line to the DRAM-cache fill-write path over a valid/ready interface.
- Single AXI ID means in-order return, so TIDs are held in an in-order queue.

Parameters:
- ID_WIDTH, `AXI_ID_WIDTH, AXI ID width.
- ID, `AXI_ID, expected RID (same ID the AR stage drives).
- TID_WIDTH, `TID_WIDTH, transaction tag width.
- AXI_DATA_WIDTH, 256, R beat width.
- LINE_WIDTH, 512, cache line width; BEATS = LINE_WIDTH/AXI_DATA_WIDTH (must be an integer ≥1).
- TIDQ_DEPTH, 8, outstanding-fill TID queue depth (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ar_fire_i  in  1  AR handshake (arvalid&&arready) at the fill AR stage
- ar_tid_i  in  TID_WIDTH  TID of the AR being issued
- tidq_full_o  out  1  TID queue full; the AR stage must not issue
- rid_i  in  ID_WIDTH  AXI RID
- rdata_i  in  AXI_DATA_WIDTH  AXI RDATA
- rresp_i  in  2  AXI RRESP
- rlast_i  in  1  AXI RLAST
- rvalid_i  in  1  AXI RVALID
- rready_o  out  1  AXI RREADY
- fill_valid_o  out  1  assembled line valid
- fill_ready_i  in  1  fill-write path ready
- fill_data_o  out  LINE_WIDTH  line; beat k occupies bits [k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
- fill_tid_o  out  TID_WIDTH  TID of the line
- fill_err_o  out  1  line has an error (SLVERR/DECERR, RID mismatch, or bad burst length)
- tidq_ovf_o  out  1  sticky: push while full; cleared only by reset

Behaviour:
- Reset (async assert, deasserted synchronously by the environment): all outputs 0; state S_IDLE; beat_cnt 0; TID queue empty; line buffer cleared.
- TID queue:
  - push on ar_fire_i; pop when the rlast beat is accepted.
  - Simultaneous push and pop: occupancy unchanged, both take effect.
  - tidq_full_o is registered occupancy == TIDQ_DEPTH.
  - Push while full: entry dropped, tidq_ovf_o set.
- FSM:
  - S_IDLE/S_COLLECT: rready_o = queue non-empty (registered). A TID pushed in cycle N makes rready_o high at N+1.
  - Beat accept = rvalid_i && rready_o. Store rdata_i at slot beat_cnt, increment beat_cnt, move S_IDLE→S_COLLECT.
  - Error accumulation: OR in rresp_i[1], and (rid_i != ID), into the line error flag.
  - Extra beats: if beat_cnt == BEATS-1 was already stored and a further non-last beat arrives, the beat is accepted but not stored, beat_cnt saturates, error flag set.
  - Accepted beat with rlast_i:
    - Set error flag if the beat index != BEATS-1.
    - Latch the queue-head TID into fill_tid_o and pop it.
    - Go to S_OUT; fill_valid_o rises next cycle (last beat accepted at N → fill_valid_o at N+1).
  - S_OUT: rready_o = 0. fill_data_o, fill_tid_o and fill_err_o are held stable while fill_valid_o && !fill_ready_i. On handshake: fill_valid_o=0, beat_cnt=0, line buffer and error flag cleared, go to S_IDLE. rready_o may assert the following cycle.
- Short burst: unfilled slots are 0, fill_err_o=1, TID still consumed.
- Reset mid-burst: partial line and all queued TIDs discarded; no output line.
- Throughput: one line per BEATS+1 cycles minimum with continuous rvalid_i and fill_ready_i.

Decomposition:
- Shared package/TYPEDEF.svh: AXI_DATA_WIDTH, LINE_WIDTH, FILL_TIDQ_DEPTH constants; RRESP encodings (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11); FSM state typedef {S_IDLE, S_COLLECT, S_OUT}.
- One sub-module: fill_tid_queue, a synchronous FIFO (width TID_WIDTH, depth TIDQ_DEPTH) with full/empty/overflow.

Test Plan:
- Push TID 0x3, then 2 R beats 0xAAAA…/0xBBBB… with rlast on beat 1 → fill_valid_o one cycle after beat 1; fill_data_o = {0xBBBB…,0xAAAA…}; fill_tid_o=0x3; fill_err_o=0.
- Push TIDs 1,2,3 back-to-back, 3 lines returned, fill_ready_i held low 4 cycles on line 2 → output stable while stalled, rready_o=0 during stall, lines emitted with TIDs 1,2,3 in order.
- Beat 0 rresp=2'b10, beat 1 OKAY → fill_err_o=1, data still assembled. Separately, rid != ID → fill_err_o=1.
- rlast on beat 0 (short burst) → fill_err_o=1, upper slot 0, TID popped; next line returns normally with err=0.
- Fill queue to 8 → tidq_full_o=1; 9th push → tidq_ovf_o=1, occupancy stays 8. Push and pop in the same cycle at occupancy 8 → tidq_full_o stays 1, no overflow.
- Assert rst after beat 0 of a line → all outputs 0 immediately; after release, rready_o=0 until a new TID is pushed.
